// File: rtl/rf_exec_ctrl.sv
// rtl/rf_exec_ctrl.sv - multi-cycle execution sequencer driving an 8x16 register file
//
// Accepts one 3-operand instruction over a valid/ready handshake, reads two
// operands from the register file, computes an ALU result and writes it back.
// Sequence per instruction: IDLE -> READ -> EXEC -> WRITE -> IDLE.
//
// Ports:
//   clk, reset                    rising-edge clock, synchronous active-high reset
//   instr_valid / instr_ready     instruction handshake (ready only in IDLE)
//   instr_op/rd/rs1/rs2/imm       instruction fields, sampled on accept
//   rd_addr_a, rd_addr_b          register file read addresses (held)
//   rf_data_a, rf_data_b          register file read data (combinational)
//   wr, wr_addr, wr_data          register file write port, active in WRITE only
//   result, carry, zero           last result and flags, held
//   done                          one-cycle pulse coincident with the write
module rf_exec_ctrl #(
    parameter int W  = 16,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [2:0]    instr_op,
    input  logic [AW-1:0] instr_rd,
    input  logic [AW-1:0] instr_rs1,
    input  logic [AW-1:0] instr_rs2,
    input  logic [W-1:0]  instr_imm,
    output logic [AW-1:0] rd_addr_a,
    output logic [AW-1:0] rd_addr_b,
    input  logic [W-1:0]  rf_data_a,
    input  logic [W-1:0]  rf_data_b,
    output logic          wr,
    output logic [AW-1:0] wr_addr,
    output logic [W-1:0]  wr_data,
    output logic [W-1:0]  result,
    output logic          carry,
    output logic          zero,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_LDI = 3'd7;

    state_t        state;
    logic [2:0]    op_q;
    logic [AW-1:0] rd_q;
    logic [W-1:0]  imm_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;

    logic [W:0]    sum;
    logic [W-1:0]  alu_res;
    logic          alu_carry;

    // ALU works only from the captured operand registers, so the register
    // file may change underneath it without affecting the result.
    always_comb begin
        sum       = {1'b0, a_q} + {1'b0, b_q};
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res   = sum[W-1:0];
                alu_carry = sum[W];
            end
            OP_SUB: begin
                alu_res   = a_q - b_q;
                alu_carry = (a_q >= b_q);   // no-borrow
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            // Only the low four bits of B form the shift amount.
            OP_SHL: alu_res = a_q << b_q[3:0];
            OP_SHR: alu_res = a_q >> b_q[3:0];
            OP_LDI: alu_res = imm_q;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            instr_ready <= 1'b1;
            op_q        <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rd_addr_a   <= '0;
            rd_addr_b   <= '0;
            wr          <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            result      <= '0;
            carry       <= 1'b0;
            zero        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid && instr_ready) begin
                        op_q        <= instr_op;
                        rd_q        <= instr_rd;
                        imm_q       <= instr_imm;
                        rd_addr_a   <= instr_rs1;
                        rd_addr_b   <= instr_rs2;
                        instr_ready <= 1'b0;
                        state       <= READ;
                    end
                end
                READ: begin
                    a_q   <= rf_data_a;
                    b_q   <= rf_data_b;
                    state <= EXEC;
                end
                EXEC: begin
                    result  <= alu_res;
                    carry   <= alu_carry;
                    zero    <= (alu_res == '0);
                    wr_data <= alu_res;
                    wr_addr <= rd_q;
                    wr      <= 1'b1;
                    done    <= 1'b1;
                    state   <= WRITE;
                end
                WRITE: begin
                    wr          <= 1'b0;
                    done        <= 1'b0;
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    wr          <= 1'b0;
                    done        <= 1'b0;
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
